// File: rtl/mux8x1_rr_sched_if.sv
// Bundle of request, data and output handshake signals for mux8x1_rr_sched.
//
// master : drives req, i, burst_len and out_ready; observes the scheduler outputs.
// slave  : the scheduler. It drives out_valid, y, sel, gnt, busy and done.
interface mux8x1_rr_sched_if #(
  parameter int BURST_W = 4
);
  logic [7:0]         req;
  logic [7:0]         i;
  logic [BURST_W-1:0] burst_len;
  logic               out_ready;
  logic               out_valid;
  logic               y;
  logic [2:0]         sel;
  logic [7:0]         gnt;
  logic               busy;
  logic               done;

  modport master (
    output req, i, burst_len, out_ready,
    input  out_valid, y, sel, gnt, busy, done
  );

  modport slave (
    input  req, i, burst_len, out_ready,
    output out_valid, y, sel, gnt, busy, done
  );
endinterface

// File: rtl/mux8x1_rr_sched.sv
// Round-robin scheduler that shares one 8:1 bit-select datapath among eight
// requesters. A winner is picked in IDLE, and its burst length is latched. The
// mux select is then held for that many accepted beats, and the scheduler
// goes back to IDLE for one cycle before it arbitrates again.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mux8x1_rr_sched_if.slave:
//            req[7:0], i[7:0], burst_len, out_ready  (inputs)
//            out_valid, y, sel[2:0], gnt[7:0], busy, done (outputs)
//          y = i[sel] is combinational through the mux instance. All other
//          outputs come from registers only.

// 8:1 bit mux built from two 4:1 stages and a final 2:1 stage.
module mux8x1_4x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);
  logic [3:0] lo_v;
  logic [3:0] hi_v;
  logic       lo_y;
  logic       hi_y;

  assign lo_v = i[3:0];
  assign hi_v = i[7:4];
  assign lo_y = lo_v[s[1:0]];
  assign hi_y = hi_v[s[1:0]];
  assign y    = s[2] ? hi_y : lo_y;
endmodule

module mux8x1_rr_sched #(
  parameter int BURST_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux8x1_rr_sched_if.slave      bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         sel_q, sel_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               done_q, done_d;

  logic               accept;
  logic               last_beat;
  logic [2:0]         winner;
  logic               y_w;

  // First set request at or after ptr, wrapping modulo 8. The scan runs from
  // the farthest offset down to ptr, so the nearest hit is kept.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int off = 7; off >= 0; off--) begin
      idx = p + 3'(off);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner    = rr_pick(bus.req, ptr_q);
  assign accept    = (state_q == GRANT) && bus.out_ready;
  assign last_beat = (cnt_q == (len_q - BURST_W'(1)));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      len_q   <= BURST_W'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req != 8'h00) state_d = GRANT;
      GRANT:   if (accept && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register updates: latch the winner in IDLE, count beats in GRANT.
  // req is ignored while a burst is in progress.
  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req != 8'h00) begin
        sel_d = winner;
        ptr_d = winner + 3'd1;
        cnt_d = '0;
        // A zero burst length means a single-beat grant.
        len_d = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
      end
    end else if (accept) begin
      cnt_d  = cnt_q + BURST_W'(1);
      done_d = last_beat;
    end
  end

  // Outputs: decoded from registered state only
  always_comb begin
    bus.out_valid = (state_q == GRANT);
    bus.busy      = (state_q == GRANT);
    bus.gnt       = (state_q == GRANT) ? (8'h01 << sel_q) : 8'h00;
    bus.sel       = sel_q;
    bus.done      = done_q;
  end

  mux8x1_4x1 u_mux (
    .i (bus.i),
    .s (sel_q),
    .y (y_w)
  );

  assign bus.y = y_w;

endmodule
